// File: rtl/sseg_scan_decoder.sv
// -----------------------------------------------------------------------------
// sseg_scan_decoder
//
// Purpose:
//   Receive-side decoder for a time-multiplexed four-digit seven-segment bus.
//   It watches the active-low anode and segment lines and waits until they are
//   stable. It then recovers, for each digit, the displayed hex nibble, the
//   decimal point, and blank/error flags. This lets the board read back what
//   the display is showing.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active low
//   an[3:0]     anode bus, active low, bit0 = rightmost digit
//   sseg[7:0]   segment bus, active low, [7]=dp, [6]=a ... [0]=g
//   hex0..hex3  recovered nibble per digit
//   dp[3:0]     recovered decimal point per digit, 1 = lit
//   blank[3:0]  digit last sampled with all of a..g dark
//   digit_err   digit last sampled with a glyph that is not a hex character
//   frame_done  one-cycle pulse once all four digits have been captured
//   stale       no capture within TIMEOUT_CYCLES (optional feature)
//
// Configuration:
//   `define SSEG_STALE_TIMEOUT_EN to build the stale-frame timeout. When the
//   macro is undefined, stale is tied low and TIMEOUT_CYCLES is unused.
// -----------------------------------------------------------------------------
module sseg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] dp,
  output logic [3:0] blank,
  output logic [3:0] digit_err,
  output logic       frame_done,
  output logic       stale
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

  // {an, sseg} goes through a two-flop synchroniser.
  // A third register holds the previous synced value so changes can be detected.
  logic [11:0] bus_s1_q, bus_s2_q, bus_prev_q;
  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]  mask_q, mask_d;
  logic        frame_q, frame_d;
  logic [3:0]  hex_q [4];
  logic [3:0]  dp_q, blank_q, err_q;

  logic [3:0] an_sync;
  logic [7:0] seg_sync;
  logic       an_valid;
  logic       changed;
  logic       capture;
  logic [1:0] sel;
  logic [3:0] sel_onehot;
  logic [4:0] dec;        // {match, value}
  logic       timeout_hit;

  assign an_sync  = bus_s2_q[11:8];
  assign seg_sync = bus_s2_q[7:0];
  assign changed  = (bus_s2_q != bus_prev_q);

  // Glyph lookup for the a..g lines (active low). The MSB of the result
  // flags a recognised hex character.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    case (seg)
      7'h01:   decode_glyph = 5'h10;
      7'h4F:   decode_glyph = 5'h11;
      7'h12:   decode_glyph = 5'h12;
      7'h06:   decode_glyph = 5'h13;
      7'h4C:   decode_glyph = 5'h14;
      7'h24:   decode_glyph = 5'h15;
      7'h20:   decode_glyph = 5'h16;
      7'h0F:   decode_glyph = 5'h17;
      7'h00:   decode_glyph = 5'h18;
      7'h04:   decode_glyph = 5'h19;
      7'h08:   decode_glyph = 5'h1A;
      7'h60:   decode_glyph = 5'h1B;
      7'h31:   decode_glyph = 5'h1C;
      7'h42:   decode_glyph = 5'h1D;
      7'h30:   decode_glyph = 5'h1E;
      7'h38:   decode_glyph = 5'h1F;
      default: decode_glyph = 5'h00;
    endcase
  endfunction

  assign dec = decode_glyph(seg_sync[6:0]);

  // An anode pattern is valid only when exactly one line is low.
  always_comb begin
    an_valid = 1'b1;
    sel      = 2'd0;
    case (an_sync)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: an_valid = 1'b0;
    endcase
  end

  assign sel_onehot = ~an_sync;

  // Dwell FSM. A capture happens once per dwell, after the synced bus has been
  // stable for STABLE_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (an_valid) state_d = SETTLE;
      end
      SETTLE: begin
        if (!an_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (changed) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          capture = 1'b1;
          state_d = CAPTURED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPTURED: begin
        cnt_d = '0;
        if (!an_valid)    state_d = IDLE;
        else if (changed) state_d = SETTLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef SSEG_STALE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q;
  logic            stale_q;

  // A capture has priority. The counter saturates at the limit until the next capture.
  assign timeout_hit = !capture && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
      stale_q  <= 1'b0;
    end else if (capture) begin
      to_cnt_q <= '0;
      stale_q  <= 1'b0;
    end else if (timeout_hit) begin
      stale_q  <= 1'b1;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign stale = stale_q;
`else
  assign timeout_hit = 1'b0;
  assign stale       = 1'b0;
`endif

  // Seen-mask: the capture that completes the frame pulses frame_done and
  // restarts the mask in the same update.
  always_comb begin
    mask_d  = mask_q;
    frame_d = 1'b0;
    if (capture) begin
      if ((mask_q | sel_onehot) == 4'hF) begin
        frame_d = 1'b1;
        mask_d  = 4'h0;
      end else begin
        mask_d = mask_q | sel_onehot;
      end
    end else if (timeout_hit) begin
      mask_d = 4'h0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_s1_q   <= '0;
      bus_s2_q   <= '0;
      bus_prev_q <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      mask_q     <= '0;
      frame_q    <= 1'b0;
    end else begin
      bus_s1_q   <= {an, sseg};
      bus_s2_q   <= bus_s1_q;
      bus_prev_q <= bus_s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      frame_q    <= frame_d;
    end
  end

  // Per-digit result registers. Only the selected digit is written on a capture.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hex_q[gi]   <= 4'h0;
        dp_q[gi]    <= 1'b0;
        blank_q[gi] <= 1'b0;
        err_q[gi]   <= 1'b0;
      end else if (capture && sel == 2'(gi)) begin
        hex_q[gi]   <= dec[4] ? dec[3:0] : 4'h0;
        dp_q[gi]    <= ~seg_sync[7];
        blank_q[gi] <= (seg_sync[6:0] == 7'h7F);
        err_q[gi]   <= !dec[4] && (seg_sync[6:0] != 7'h7F);
      end
    end
  end

  assign hex0       = hex_q[0];
  assign hex1       = hex_q[1];
  assign hex2       = hex_q[2];
  assign hex3       = hex_q[3];
  assign dp         = dp_q;
  assign blank      = blank_q;
  assign digit_err  = err_q;
  assign frame_done = frame_q;

endmodule
